// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with arbitrary depth, selectable registered or first-word-fall-through read,
// threshold flags, occupancy count, sticky error flags and synchronous flush.
module sync_fifo_v2 #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 7,
   parameter int unsigned AF_LEVEL   = 6,
   parameter int unsigned AE_LEVEL   = 1,
   parameter int unsigned FWFT       = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         w_en,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         r_en,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;

   // Explicit wrap so non-power-of-2 depths never index past the last entry.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign wr_acc = w_en & ~full & ~flush;
   assign rd_acc = r_en & ~empty & ~flush;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rdata_d     = rdata_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (rd_acc) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            rdata_d  = mem[rd_ptr_q];
         end
         unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (w_en && full) begin
            overflow_d = 1'b1;
         end
         if (r_en && empty) begin
            underflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rdata_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rdata_q     <= rdata_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr_acc) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   // FWFT presents the head directly; forced to zero while empty so reset shows data_out=0.
   assign data_out = (FWFT != 0) ? (empty ? '0 : mem[rd_ptr_q]) : rdata_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: a standard-read and an FWFT instance share one stimulus stream and
// are compared every cycle against a queue model, plus directed literal expectations.
module tb_sync_fifo_v2;

   localparam int DEPTH = 7;
   localparam int AF    = 6;
   localparam int AE    = 1;

   logic       clk = 1'b0;
   logic       rst_n, flush, w_en, r_en;
   logic [7:0] data_in;

   logic [7:0] data_out_s, data_out_f;
   logic       full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
   logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
   logic [2:0] count_s, count_f;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(data_out_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
      .almost_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s)
   );

   sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(data_out_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
      .almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(unf_f)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a plain queue of stored words.
   logic [7:0] q[$];
   bit         m_ovf, m_unf, started;
   logic [7:0] m_dout;

   always @(posedge clk) begin
      started = 1'b1;
      if (!rst_n) begin
         q.delete();
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
         m_dout = 8'h00;
      end else if (flush) begin
         q.delete();
      end else begin
         bit was_full, was_empty;
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         if (r_en) begin
            if (was_empty) m_unf = 1'b1;
            else m_dout = q.pop_front();
         end
         if (w_en) begin
            if (was_full) m_ovf = 1'b1;
            else q.push_back(data_in);
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("std.count", 32'(count_s), q.size());
         check("std.full", 32'(full_s), 32'(q.size() == DEPTH));
         check("std.empty", 32'(empty_s), 32'(q.size() == 0));
         check("std.almost_full", 32'(af_s), 32'(q.size() >= AF));
         check("std.almost_empty", 32'(ae_s), 32'(q.size() <= AE));
         check("std.overflow", 32'(ovf_s), 32'(m_ovf));
         check("std.underflow", 32'(unf_s), 32'(m_unf));
         check("std.data_out", 32'(data_out_s), 32'(m_dout));
         check("fwft.count", 32'(count_f), q.size());
         check("fwft.full", 32'(full_f), 32'(q.size() == DEPTH));
         check("fwft.empty", 32'(empty_f), 32'(q.size() == 0));
         check("fwft.almost_full", 32'(af_f), 32'(q.size() >= AF));
         check("fwft.almost_empty", 32'(ae_f), 32'(q.size() <= AE));
         check("fwft.overflow", 32'(ovf_f), 32'(m_ovf));
         check("fwft.underflow", 32'(unf_f), 32'(m_unf));
         if (q.size() != 0) check("fwft.data_out", 32'(data_out_f), 32'(q[0]));
      end
   end

   task automatic step(input logic w, input logic r, input logic [7:0] d, input logic f,
                       input logic rn);
      w_en    = w;
      r_en    = r;
      data_in = d;
      flush   = f;
      rst_n   = rn;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
      step(0, 0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 0, 0);
      check("rst.count", 32'(count_s), 0);
      check("rst.empty", 32'(empty_s), 1);
      check("rst.almost_empty", 32'(ae_s), 1);
      check("rst.almost_full", 32'(af_s), 0);
      check("rst.data_out", 32'(data_out_s), 0);

      // Fill with 0x10..0x16, then one write too many.
      for (int i = 0; i < 7; i++) begin
         step(1, 0, 8'(8'h10 + i), 0, 1);
         if (i == 4) check("fill.af_at5", 32'(af_s), 0);
         if (i == 5) check("fill.af_at6", 32'(af_s), 1);
      end
      check("fill.full", 32'(full_s), 1);
      check("fill.count", 32'(count_s), 7);
      step(1, 0, 8'h17, 0, 1);
      check("fill.ovf_count", 32'(count_s), 7);
      check("fill.overflow", 32'(ovf_s), 1);

      // Drain in order, one-cycle latency.
      for (int i = 0; i < 7; i++) begin
         step(0, 1, 8'h00, 0, 1);
         check("drain.data_out", 32'(data_out_s), 32'(8'h10 + i));
         if (i == 4) check("drain.ae_at2", 32'(ae_s), 0);
         if (i == 5) check("drain.ae_at1", 32'(ae_s), 1);
      end
      check("drain.empty", 32'(empty_s), 1);
      step(0, 1, 8'h00, 0, 1);
      check("drain.underflow", 32'(unf_s), 1);
      check("drain.hold", 32'(data_out_s), 32'h16);

      // Continuous stream at count=3 across several pointer wraps.
      for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h20 + i), 0, 1);
      for (int i = 0; i < 20; i++) begin
         step(1, 1, 8'(8'h23 + i), 0, 1);
         check("wrap.data_out", 32'(data_out_s), 32'(8'h20 + i));
      end
      check("wrap.count", 32'(count_s), 3);
      for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, 1);
      check("wrap.tail", 32'(data_out_s), 32'h36);

      // FWFT fall-through and pop.
      step(1, 0, 8'hA5, 0, 1);
      check("fwft.first", 32'(data_out_f), 32'hA5);
      check("fwft.nonempty", 32'(empty_f), 0);
      step(1, 0, 8'h5A, 0, 1);
      check("fwft.head_held", 32'(data_out_f), 32'hA5);
      step(0, 1, 8'h00, 0, 1);
      check("fwft.pop", 32'(data_out_f), 32'h5A);
      step(0, 1, 8'h00, 0, 1);
      check("fwft.empty", 32'(empty_f), 1);

      // Simultaneous read+write at empty and at full.
      step(0, 0, 8'h00, 0, 0);
      check("sim.unf_clear", 32'(unf_s), 0);
      step(1, 1, 8'h30, 0, 1);
      check("sim.empty_count", 32'(count_s), 1);
      check("sim.empty_unf", 32'(unf_s), 1);
      for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h31 + i), 0, 1);
      check("sim.full_count", 32'(count_s), 7);
      step(1, 1, 8'h37, 0, 1);
      check("sim.full_oldest", 32'(data_out_s), 32'h30);
      check("sim.full_ovf", 32'(ovf_s), 1);
      check("sim.full_count_after", 32'(count_s), 6);

      // Flush at count=4 with a write pending.
      step(0, 1, 8'h00, 0, 1);
      step(0, 1, 8'h00, 0, 1);
      check("flush.pre_count", 32'(count_s), 4);
      step(1, 0, 8'h99, 1, 1);
      check("flush.count", 32'(count_s), 0);
      check("flush.empty", 32'(empty_s), 1);
      check("flush.ovf_kept", 32'(ovf_s), 1);
      check("flush.unf_kept", 32'(unf_s), 1);
      check("flush.dout_hold", 32'(data_out_s), 32'h32);

      step(0, 0, 8'h00, 0, 0);
      step(1, 1, 8'h55, 1, 1);
      check("flush.no_unf", 32'(unf_s), 0);
      check("flush.no_write", 32'(count_s), 0);

      // Reset in the middle of traffic.
      step(1, 0, 8'h40, 0, 1);
      step(1, 0, 8'h41, 0, 1);
      step(0, 1, 8'h00, 0, 1);
      check("mid.data_out", 32'(data_out_s), 32'h40);
      step(1, 1, 8'h42, 0, 0);
      check("mid.count", 32'(count_s), 0);
      check("mid.data_out_rst", 32'(data_out_s), 0);
      check("mid.empty", 32'(empty_s), 1);
      check("mid.full", 32'(full_s), 0);
      step(1, 0, 8'h50, 0, 1);
      step(0, 1, 8'h00, 0, 1);
      check("post.data_out", 32'(data_out_s), 32'h50);
      step(0, 0, 8'h00, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
